// File: rtl/alu_issue_wb.sv
// Decode/issue and writeback stage around the 16-bit ALU: one instruction per 3 cycles (2 for non-ALU types).
// Operands are read at the accept edge, the ALU is enabled for one cycle, and the result is committed on the WB exit edge.
module alu_issue_wb #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              alu_en,
  output logic [1:0]        alu_type,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_r1,
  output logic [DATA_W-1:0] alu_r2,
  input  logic [DATA_W-1:0] alu_acc,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_bool,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] res_acc;
  logic [3:0]        res_flags;
  logic              accept;

  function automatic logic is_imm(input logic [4:0] op);
    case (op)
      5'b00100, 5'b00110, 5'b01111, 5'b10001, 5'b00111, 5'b10011: is_imm = 1'b1;
      default:                                                    is_imm = 1'b0;
    endcase
  endfunction

  function automatic logic is_result(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01110, 5'b01111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101: is_result = 1'b1;
      default:                                                    is_result = 1'b0;
    endcase
  endfunction

  assign accept   = instr_valid & instr_ready;
  assign dbg_data = regs[dbg_addr];

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (accept) state_nxt = (instr[15:14] == 2'b00) ? ISSUE : WB;
      end
      ISSUE: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        illegal   = instr_q[15];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      alu_en     <= 1'b0;
      alu_type   <= 2'b00;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      res_acc    <= '0;
      res_flags  <= '0;
      flags      <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr;
        if (instr[15:14] == 2'b00) begin
          alu_en     <= 1'b1;
          alu_type   <= 2'b00;
          alu_opcode <= instr[13:9];
          // Immediate forms use rd as the first source; the write-back happens two edges later.
          if (is_imm(instr[13:9])) begin
            alu_r1 <= regs[instr[8:6]];
            alu_r2 <= DATA_W'(instr[5:0]);
          end else begin
            alu_r1 <= regs[instr[5:3]];
            alu_r2 <= regs[instr[2:0]];
          end
        end
      end
      if (state == ISSUE) begin
        alu_en    <= 1'b0;
        res_acc   <= alu_acc;
        res_flags <= {alu_carry, alu_overflow, alu_zero, alu_bool};
      end
      if (state == WB) begin
        case (instr_q[15:14])
          2'b00: begin
            flags <= res_flags;
            if (is_result(instr_q[13:9])) regs[instr_q[8:6]] <= res_acc;
          end
          2'b01:   regs[instr_q[13:11]] <= DATA_W'(instr_q[10:0]);
          default: ;
        endcase
      end
    end
  end

endmodule
